// File: rtl/sat_reg_arbiter_if.sv
// Two-requester op bus for the shared saturating register: req/op/data in, ack out.
interface sat_reg_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             a_req;
    logic [1:0]       a_op;
    logic [WIDTH-1:0] a_data;
    logic             a_ack;
    logic             b_req;
    logic [1:0]       b_op;
    logic [WIDTH-1:0] b_data;
    logic             b_ack;

    modport master (
        output a_req, a_op, a_data, b_req, b_op, b_data,
        input  a_ack, b_ack
    );

    modport slave (
        input  a_req, a_op, a_data, b_req, b_op, b_data,
        output a_ack, b_ack
    );
endinterface

// File: rtl/sat_reg_arbiter.sv
// Round-robin arbiter sharing one saturating register between two four-phase requesters.
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and latches op/data on grant
//   EXEC  | applies the latched op with clamping to [MIN_VAL, MAX_VAL]
//   ACK   | ack held to the granted requester until its req drops
module sat_reg_arbiter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] MIN_VAL   = '0,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    sat_reg_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]  value,
    output logic              at_max,
    output logic              at_min,
    output logic              sat_evt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0]     OP_INC  = 2'b00;
    localparam logic [1:0]     OP_DEC  = 2'b01;
    localparam logic [1:0]     OP_LOAD = 2'b10;
    localparam logic [WIDTH:0] MIN_X   = {1'b0, MIN_VAL};
    localparam logic [WIDTH:0] MAX_X   = {1'b0, MAX_VAL};

    state_t           state;
    state_t           state_nxt;
    logic             grant_b;
    logic             last_grant_b;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             pick_a;
    logic             pick_b;
    logic             granted_req;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result;
    logic             clip;
    logic             a_ack_q;
    logic             b_ack_q;

    assign bus.a_ack = a_ack_q;
    assign bus.b_ack = b_ack_q;

    // Bound comparisons go through a function so a zero MIN_VAL does not fold into a constant test.
    function automatic logic lt(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        return x < y;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        pick_a      = bus.a_req && (!bus.b_req || last_grant_b);
        pick_b      = bus.b_req && !pick_a;
        granted_req = grant_b ? bus.b_req : bus.a_req;
        state_nxt   = state;
        case (state)
            IDLE:    if (pick_a || pick_b) state_nxt = EXEC;
            EXEC:    state_nxt = ACK;
            ACK:     if (!granted_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum    = {1'b0, value} + {1'b0, data_q};
        diff   = {1'b0, value} - {1'b0, data_q};
        result = value;
        clip   = 1'b0;
        case (op_q)
            OP_INC: begin
                if (lt(MAX_X, sum)) begin
                    result = MAX_VAL;
                    clip   = 1'b1;
                end else begin
                    result = sum[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                // diff[WIDTH] is the borrow, i.e. value < data
                if (diff[WIDTH] || lt(diff, MIN_X)) begin
                    result = MIN_VAL;
                    clip   = 1'b1;
                end else begin
                    result = diff[WIDTH-1:0];
                end
            end
            OP_LOAD: begin
                if (lt(MAX_X, {1'b0, data_q})) begin
                    result = MAX_VAL;
                    clip   = 1'b1;
                end else if (lt({1'b0, data_q}, MIN_X)) begin
                    result = MIN_VAL;
                    clip   = 1'b1;
                end else begin
                    result = data_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value        <= RESET_VAL;
            at_max       <= (RESET_VAL == MAX_VAL);
            at_min       <= (RESET_VAL == MIN_VAL);
            sat_evt      <= 1'b0;
            busy         <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            grant_b      <= 1'b0;
            last_grant_b <= 1'b1;
            op_q         <= 2'b00;
            data_q       <= '0;
        end else begin
            busy    <= (state_nxt != IDLE);
            a_ack_q <= (state_nxt == ACK) && !grant_b;
            b_ack_q <= (state_nxt == ACK) && grant_b;
            sat_evt <= (state == EXEC) && clip;
            if (state == IDLE && (pick_a || pick_b)) begin
                grant_b      <= pick_b;
                last_grant_b <= pick_b;
                op_q         <= pick_b ? bus.b_op : bus.a_op;
                data_q       <= pick_b ? bus.b_data : bus.a_data;
            end
            if (state == EXEC) begin
                value  <= result;
                at_max <= (result == MAX_VAL);
                at_min <= (result == MIN_VAL);
            end
        end
    end

endmodule
